// File: rtl/dbus_if.sv
// Request/grant bus between one master and the data-RAM arbiter.
// The master drives the request side; the arbiter returns grant and read data.
interface dbus_if #(
    parameter int AWIDTH = 16,
    parameter int DWIDTH = 16
);
    logic              req;
    logic              we;
    logic              lock;
    logic [AWIDTH-1:0] addr;
    logic [DWIDTH-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DWIDTH-1:0] rdata;

    modport master (
        output req, we, lock, addr, wdata,
        input  gnt, rvalid, rdata
    );

    modport slave (
        input  req, we, lock, addr, wdata,
        output gnt, rvalid, rdata
    );
endinterface

// File: rtl/dbus_arbiter.sv
// Two-master arbiter for a single-port data RAM: round-robin or fixed
// priority, bus lock for read-modify-write, in-order read-data return.
module dbus_arbiter #(
    parameter int AWIDTH      = 16,
    parameter int DWIDTH      = 16,
    parameter int MEM_LATENCY = 1,
    parameter int FIXED_PRIO  = 0
) (
    input  logic              clk,
    input  logic              rst,
    dbus_if.slave             m0,
    dbus_if.slave             m1,
    output logic              mem_en,
    output logic              mem_we,
    output logic [AWIDTH-1:0] mem_addr,
    output logic [DWIDTH-1:0] mem_wdata,
    input  logic [DWIDTH-1:0] mem_rdata
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic       rr_last_q;
    logic       rr_last_d;

    logic gnt0;
    logic gnt1;
    logic pick1;

    logic [MEM_LATENCY-1:0] vld_q;
    logic [MEM_LATENCY-1:0] vld_d;
    logic [MEM_LATENCY-1:0] own_q;
    logic [MEM_LATENCY-1:0] own_d;

    logic tail_vld;
    logic tail_own;

    // Conflict winner is the port opposite the last grant unless fixed priority.
    always_comb begin
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        pick1 = (FIXED_PRIO == 0) && !rr_last_q;
        case (state_q)
            OWN0: gnt0 = m0.req;
            OWN1: gnt1 = m1.req;
            default: begin
                if (m0.req && m1.req) begin
                    gnt1 = pick1;
                    gnt0 = !pick1;
                end else begin
                    gnt0 = m0.req;
                    gnt1 = m1.req;
                end
            end
        endcase
        if (rst) begin
            gnt0 = 1'b0;
            gnt1 = 1'b0;
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        if (gnt0) rr_last_d = 1'b0;
        if (gnt1) rr_last_d = 1'b1;
        case (state_q)
            OWN0: begin
                if (!m0.req || !m0.lock) state_d = IDLE;
            end
            OWN1: begin
                if (!m1.req || !m1.lock) state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                if (gnt0 && m0.lock) state_d = OWN0;
                if (gnt1 && m1.lock) state_d = OWN1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
        end
    end

    always_comb begin
        mem_en    = gnt0 | gnt1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        unique case (1'b1)
            gnt0: begin
                mem_we    = m0.we;
                mem_addr  = m0.addr;
                mem_wdata = m0.wdata;
            end
            gnt1: begin
                mem_we    = m1.we;
                mem_addr  = m1.addr;
                mem_wdata = m1.wdata;
            end
            default: ;
        endcase
    end

    // One slot per cycle of RAM latency; the tail lines up with mem_rdata.
    always_comb begin
        vld_d    = '0;
        own_d    = '0;
        vld_d[0] = mem_en & ~mem_we;
        own_d[0] = gnt1;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            own_d[i] = own_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            own_q <= '0;
        end else begin
            vld_q <= vld_d;
            own_q <= own_d;
        end
    end

    assign tail_vld = vld_q[MEM_LATENCY-1];
    assign tail_own = own_q[MEM_LATENCY-1];

    assign m0.gnt    = gnt0;
    assign m1.gnt    = gnt1;
    assign m0.rvalid = tail_vld & ~tail_own;
    assign m1.rvalid = tail_vld & tail_own;
    assign m0.rdata  = m0.rvalid ? mem_rdata : '0;
    assign m1.rdata  = m1.rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dbus_arbiter.sv
// Drives a round-robin (latency 1) and a fixed-priority (latency 3) arbiter
// with directed and random traffic, checked against a per-cycle reference.
module tb_dbus_arbiter;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dbus_if ia0 ();
    dbus_if ia1 ();
    dbus_if ib0 ();
    dbus_if ib1 ();

    logic [1:0]  req_v  [2];
    logic [1:0]  we_v   [2];
    logic [1:0]  lock_v [2];
    logic [15:0] addr_v [2][2];
    logic [15:0] wd_v   [2][2];

    assign ia0.req   = req_v[0][0];
    assign ia0.we    = we_v[0][0];
    assign ia0.lock  = lock_v[0][0];
    assign ia0.addr  = addr_v[0][0];
    assign ia0.wdata = wd_v[0][0];
    assign ia1.req   = req_v[0][1];
    assign ia1.we    = we_v[0][1];
    assign ia1.lock  = lock_v[0][1];
    assign ia1.addr  = addr_v[0][1];
    assign ia1.wdata = wd_v[0][1];
    assign ib0.req   = req_v[1][0];
    assign ib0.we    = we_v[1][0];
    assign ib0.lock  = lock_v[1][0];
    assign ib0.addr  = addr_v[1][0];
    assign ib0.wdata = wd_v[1][0];
    assign ib1.req   = req_v[1][1];
    assign ib1.we    = we_v[1][1];
    assign ib1.lock  = lock_v[1][1];
    assign ib1.addr  = addr_v[1][1];
    assign ib1.wdata = wd_v[1][1];

    logic        en_a, we_a, en_b, we_b;
    logic [15:0] ad_a, wd_a, rd_a, ad_b, wd_b, rd_b;

    dbus_arbiter #(.MEM_LATENCY(1), .FIXED_PRIO(0)) u_a (
        .clk(clk), .rst(rst), .m0(ia0), .m1(ia1),
        .mem_en(en_a), .mem_we(we_a), .mem_addr(ad_a),
        .mem_wdata(wd_a), .mem_rdata(rd_a)
    );

    dbus_arbiter #(.MEM_LATENCY(3), .FIXED_PRIO(1)) u_b (
        .clk(clk), .rst(rst), .m0(ib0), .m1(ib1),
        .mem_en(en_b), .mem_we(we_b), .mem_addr(ad_b),
        .mem_wdata(wd_b), .mem_rdata(rd_b)
    );

    // Write-first synchronous RAMs with read pipelines of depth 1 and 3.
    logic [15:0] ram_a [256];
    logic [15:0] ram_b [256];
    logic [15:0] pa [1];
    logic [15:0] pb [3];

    always @(posedge clk) begin
        if (en_a && we_a) ram_a[ad_a[7:0]] <= wd_a;
        pa[0] <= (en_a && !we_a) ? ram_a[ad_a[7:0]] : 16'h0;
    end

    always @(posedge clk) begin
        if (en_b && we_b) ram_b[ad_b[7:0]] <= wd_b;
        pb[0] <= (en_b && !we_b) ? ram_b[ad_b[7:0]] : 16'h0;
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end

    assign rd_a = pa[0];
    assign rd_b = pb[2];

    logic [1:0]  o_gnt [2];
    logic [1:0]  o_rv  [2];
    logic [15:0] o_rd  [2][2];
    logic        o_en  [2];
    logic        o_we  [2];
    logic [15:0] o_ad  [2];
    logic [15:0] o_wd  [2];

    assign o_gnt[0]   = {ia1.gnt, ia0.gnt};
    assign o_gnt[1]   = {ib1.gnt, ib0.gnt};
    assign o_rv[0]    = {ia1.rvalid, ia0.rvalid};
    assign o_rv[1]    = {ib1.rvalid, ib0.rvalid};
    assign o_rd[0][0] = ia0.rdata;
    assign o_rd[0][1] = ia1.rdata;
    assign o_rd[1][0] = ib0.rdata;
    assign o_rd[1][1] = ib1.rdata;
    assign o_en[0]    = en_a;
    assign o_en[1]    = en_b;
    assign o_we[0]    = we_a;
    assign o_we[1]    = we_b;
    assign o_ad[0]    = ad_a;
    assign o_ad[1]    = ad_b;
    assign o_wd[0]    = wd_a;
    assign o_wd[1]    = wd_b;

    // Reference: current owner (-1 none), last winner, expected RAM
    // contents and a ring of expected returns indexed by due cycle.
    int          owner [2];
    bit          last  [2];
    int          lat   [2];
    bit          fixed [2];
    logic [15:0] emem  [2][256];
    bit          ev    [2][8];
    int          ep    [2][8];
    logic [15:0] ed    [2][8];
    logic [1:0]  lg    [2];
    int          cyc;
    int          checks;
    int          errors;

    task automatic chk(input int k, input string tag,
                       input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cyc%0d observed=%h expected=%h",
                   tag, k, cyc, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            logic [1:0]  g;
            logic [1:0]  erv;
            logic [15:0] erd [2];
            int          w;
            int          s;
            g = '0;
            w = -1;
            if (!rst) begin
                if (owner[k] >= 0)
                    g[owner[k]] = req_v[k][owner[k]];
                else if (req_v[k] == 2'b11)
                    g[fixed[k] ? 0 : (last[k] ? 0 : 1)] = 1'b1;
                else
                    g = req_v[k];
            end
            if (g[1]) w = 1;
            else if (g[0]) w = 0;
            s = cyc % 8;
            erv = '0;
            erd[0] = '0;
            erd[1] = '0;
            if (!rst && ev[k][s]) begin
                erv[ep[k][s]] = 1'b1;
                erd[ep[k][s]] = ed[k][s];
            end
            ev[k][s] = 1'b0;
            chk(k, "gnt", {14'b0, o_gnt[k]}, {14'b0, g});
            chk(k, "mem_en", {15'b0, o_en[k]}, {15'b0, |g});
            if (w >= 0) begin
                chk(k, "mem_we", {15'b0, o_we[k]}, {15'b0, we_v[k][w]});
                chk(k, "mem_addr", o_ad[k], addr_v[k][w]);
                chk(k, "mem_wdata", o_wd[k], wd_v[k][w]);
            end
            chk(k, "rvalid", {14'b0, o_rv[k]}, {14'b0, erv});
            chk(k, "rdata0", o_rd[k][0], erd[0]);
            chk(k, "rdata1", o_rd[k][1], erd[1]);
            if (rst) begin
                owner[k] = -1;
                last[k]  = 1'b1;
                for (int j = 0; j < 8; j++) ev[k][j] = 1'b0;
            end else if (w >= 0) begin
                last[k] = w[0];
                if (!we_v[k][w]) begin
                    s = (cyc + lat[k]) % 8;
                    ev[k][s] = 1'b1;
                    ep[k][s] = w;
                    ed[k][s] = emem[k][addr_v[k][w][7:0]];
                end else begin
                    emem[k][addr_v[k][w][7:0]] = wd_v[k][w];
                end
                owner[k] = lock_v[k][w] ? w : -1;
            end else begin
                owner[k] = -1;
            end
            lg[k] = g;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set(input int p, input logic r, input logic w,
                       input logic l, input logic [15:0] a,
                       input logic [15:0] d);
        for (int k = 0; k < 2; k++) begin
            req_v[k][p]  = r;
            we_v[k][p]   = w;
            lock_v[k][p] = l;
            addr_v[k][p] = a;
            wd_v[k][p]   = d;
        end
    endtask

    task automatic rnd_inputs();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 2; p++) begin
                if (req_v[k][p] && !lg[k][p] && ($urandom % 8) != 0)
                    continue;
                req_v[k][p]  = ($urandom % 4) != 0;
                we_v[k][p]   = $urandom % 2 == 1;
                lock_v[k][p] = ($urandom % 5) == 0;
                addr_v[k][p] = 16'($urandom % 16);
                wd_v[k][p]   = 16'($urandom);
            end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        lat[0] = 1;
        lat[1] = 3;
        fixed[0] = 1'b0;
        fixed[1] = 1'b1;
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1;
            last[k]  = 1'b1;
            lg[k]    = '0;
            for (int j = 0; j < 8; j++) begin
                ev[k][j] = 1'b0;
                ep[k][j] = 0;
                ed[k][j] = '0;
            end
        end
        for (int i = 0; i < 256; i++) begin
            ram_a[i]   = 16'(i * 257) ^ 16'h5A5A;
            ram_b[i]   = 16'(i * 257) ^ 16'h5A5A;
            emem[0][i] = 16'(i * 257) ^ 16'h5A5A;
            emem[1][i] = 16'(i * 257) ^ 16'h5A5A;
        end
        ram_a[16'h10] = 16'hBEEF;
        ram_b[16'h10] = 16'hBEEF;
        emem[0][16'h10] = 16'hBEEF;
        emem[1][16'h10] = 16'hBEEF;
        set(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Reset held with m0 requesting, then released: same-cycle grant.
        set(0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
        step();
        step();
        rst = 1'b0;
        step();
        set(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (4) step();

        // Continuous conflict.
        set(0, 1'b1, 1'b0, 1'b0, 16'h0003, 16'h0);
        set(1, 1'b1, 1'b0, 1'b0, 16'h0007, 16'h0);
        repeat (6) step();
        set(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (4) step();

        // Locked read-modify-write from m1 while m0 waits.
        set(1, 1'b1, 1'b0, 1'b1, 16'h0020, 16'h0);
        step();
        set(0, 1'b1, 1'b0, 1'b0, 16'h0030, 16'h0);
        set(1, 1'b1, 1'b1, 1'b0, 16'h0020, 16'h1234);
        step();
        set(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        step();
        set(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set(1, 1'b1, 1'b0, 1'b0, 16'h0020, 16'h0);
        step();
        set(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (4) step();

        // Reset one cycle after a granted read.
        set(0, 1'b1, 1'b0, 1'b0, 16'h0010, 16'h0);
        step();
        set(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (5) step();

        // Random traffic with occasional resets.
        for (int n = 0; n < 3000; n++) begin
            rst = ($urandom % 150) == 0;
            rnd_inputs();
            step();
        end
        rst = 1'b0;
        set(0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        set(1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        repeat (5) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
